// File: rtl/median_driver.sv
// Median-operator driver: buffers a window of pixels, streams it to an external
// median operator as one strobe burst, waits for the result and hands it downstream.
module median_driver #(
  parameter int WIDTH    = 8,
  parameter int N_PIXELS = 9,
  parameter int TIMEOUT  = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  output logic             MED_DSI,
  output logic [WIDTH-1:0] MED_DI,
  input  logic             MED_DSO,
  input  logic [WIDTH-1:0] MED_DO,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  input  logic             OUT_READY,
  input  logic             CLR_ERR,
  output logic             ERR
);

  localparam int IDX_W = $clog2(N_PIXELS) + 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             in_ready_q, in_ready_d;
  logic             med_dsi_q, med_dsi_d;
  logic [WIDTH-1:0] med_di_q, med_di_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] buf_q [N_PIXELS];

  logic             accept;
  logic             timeout;
  logic [IDX_W-1:0] nxt_idx;
  logic [WIDTH-1:0] nxt_pix;
  logic [WIDTH-1:0] first_pix;

  assign accept = (state_q == ST_LOAD) && in_ready_q && IN_VALID;

  // With a one-pixel window the first burst pixel is still on IN_DATA.
  assign first_pix = (N_PIXELS == 1) ? IN_DATA : buf_q[0];

  always_comb begin
    nxt_idx = idx_q + IDX_W'(1);
    nxt_pix = '0;
    for (int i = 0; i < N_PIXELS; i++) begin
      if (nxt_idx == IDX_W'(i)) begin
        nxt_pix = buf_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    med_dsi_d   = 1'b0;
    med_di_d    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    timeout     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d   = ST_SEND;
            idx_d     = '0;
            med_dsi_d = 1'b1;
            med_di_d  = first_pix;
          end else begin
            idx_d = nxt_idx;
          end
        end
      end
      ST_SEND: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          wcnt_d  = '0;
        end else begin
          idx_d     = nxt_idx;
          med_dsi_d = 1'b1;
          med_di_d  = nxt_pix;
        end
      end
      ST_WAIT: begin
        // A result strobe on the last allowed cycle still wins over the timeout.
        if (MED_DSO) begin
          state_d     = ST_HOLD;
          out_data_d  = MED_DO;
          out_valid_d = 1'b1;
          wcnt_d      = '0;
        end else if (wcnt_q == LAST_WAIT) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          wcnt_d  = '0;
          timeout = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
        wcnt_d  = '0;
      end
    endcase
    in_ready_d = (state_d == ST_LOAD);
    err_d      = timeout | (err_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      wcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      med_dsi_q   <= 1'b0;
      med_di_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      in_ready_q  <= in_ready_d;
      med_dsi_q   <= med_dsi_d;
      med_di_q    <= med_di_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Pixel storage needs no reset; slots are always rewritten before being sent.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_PIXELS; i++) begin
      if (accept && (idx_q == IDX_W'(i))) begin
        buf_q[i] <= IN_DATA;
      end
    end
  end

  assign IN_READY  = in_ready_q;
  assign MED_DSI   = med_dsi_q;
  assign MED_DI    = med_di_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_median_driver.sv
// Scoreboard testbench for median_driver: a median-operator model answers the
// DUT's bursts, and a window-level reference model predicts bursts and results.
module tb_median_driver;

  localparam int WIDTH     = 8;
  localparam int N_PIXELS  = 9;
  localparam int TIMEOUT   = 64;
  localparam int DSO_DELAY = 12;

  logic             CLK;
  logic             nRST;
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_READY;
  logic             MED_DSI;
  logic [WIDTH-1:0] MED_DI;
  logic             MED_DSO;
  logic [WIDTH-1:0] MED_DO;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_READY;
  logic             CLR_ERR;
  logic             ERR;

  int checks;
  int errors;
  int cycleCnt;
  int burstQ[$];
  int expQ[$];
  int winQ[$];
  bit expectNoResult;
  bit opNever;
  int strayCount;
  int outReadyMode;
  int firstAcceptCyc;
  int lastAcceptCyc;

  median_driver #(
    .WIDTH(WIDTH),
    .N_PIXELS(N_PIXELS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .IN_VALID(IN_VALID),
    .IN_DATA(IN_DATA),
    .IN_READY(IN_READY),
    .MED_DSI(MED_DSI),
    .MED_DI(MED_DI),
    .MED_DSO(MED_DSO),
    .MED_DO(MED_DO),
    .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA),
    .OUT_READY(OUT_READY),
    .CLR_ERR(CLR_ERR),
    .ERR(ERR)
  );

  // Free-running clock and a cycle counter used to measure accept spacing.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    cycleCnt = 0;
    forever begin
      @(posedge CLK);
      cycleCnt++;
    end
  end

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Median of a window, straight from its definition: sort and take the middle.
  function automatic int medianOf(input int q[$]);
    int s[$];
    s = q;
    s.sort();
    return s[s.size() / 2];
  endfunction

  // Reference model: every accepted pixel joins the window; a full window
  // predicts the burst contents (in order) and, unless the operator is mute, the median.
  task automatic modelAccept(input int px);
    winQ.push_back(px);
    if (winQ.size() == 1) firstAcceptCyc = cycleCnt;
    lastAcceptCyc = cycleCnt;
    if (winQ.size() == N_PIXELS) begin
      foreach (winQ[i]) burstQ.push_back(winQ[i]);
      if (!expectNoResult) expQ.push_back(medianOf(winQ));
      winQ.delete();
    end
  endtask

  // Offer one pixel, hold it until accepted, then idle for 'gap' cycles.
  // Called and returns on a falling edge.
  task automatic applyStimulus(input int px, input int gap);
    int  w;
    bit  last;
    w = 0;
    IN_VALID = 1'b1;
    IN_DATA  = px[WIDTH-1:0];
    while (IN_READY !== 1'b1 && w < 400) begin
      @(negedge CLK);
      w++;
    end
    if (IN_READY !== 1'b1) begin
      checkOutput("accept_wait", 32'(IN_READY), 1);
      IN_VALID = 1'b0;
      return;
    end
    last = (winQ.size() == N_PIXELS - 1);
    modelAccept(px);
    @(negedge CLK);
    IN_VALID = 1'b0;
    if (last) begin
      checkOutput("in_ready_drop", 32'(IN_READY), 0);
      checkOutput("send_start", 32'(MED_DSI), 1);
    end
    repeat (gap) @(negedge CLK);
  endtask

  task automatic feedWindow(input int gapMax);
    for (int i = 0; i < N_PIXELS; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, gapMax)));
    end
  endtask

  // Drain: wait (bounded) until every predicted result has been seen and handed off.
  task automatic waitResults();
    int w;
    w = 0;
    while ((expQ.size() != 0 || OUT_VALID === 1'b1) && w < 1500) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("result_wait", expQ.size(), 0);
  endtask

  // Feed a window to a mute operator and stop on the 64th WAIT cycle (index 63).
  task automatic reachWaitEnd();
    int w;
    w = 0;
    opNever = 1'b1;
    expectNoResult = 1'b1;
    feedWindow(0);
    while (MED_DSI === 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("dsi_fall_wait", 32'(MED_DSI), 0);
    repeat (TIMEOUT - 1) @(negedge CLK);
    expectNoResult = 1'b0;
  endtask

  // Median-operator model: collects the DSI burst, answers DSO_DELAY cycles
  // after DSI falls (unless mute), and emits stray strobes on request.
  initial begin : medianOperator
    int opQ[$];
    int cd;
    int pend;
    bit dsiPrev;
    int served;
    cd = 0;
    pend = 0;
    dsiPrev = 1'b0;
    served = 0;
    MED_DSO = 1'b0;
    MED_DO = '0;
    forever begin
      @(negedge CLK);
      MED_DSO = 1'b0;
      if (nRST !== 1'b1) begin
        opQ.delete();
        cd = 0;
        dsiPrev = 1'b0;
        served = strayCount;
        continue;
      end
      if (strayCount != served) begin
        served++;
        MED_DSO = 1'b1;
        MED_DO  = 8'hAB;
      end
      if (MED_DSI === 1'b1) opQ.push_back(int'(MED_DI));
      if (dsiPrev && MED_DSI !== 1'b1) begin
        if (!opNever) begin
          pend = medianOf(opQ);
          cd = DSO_DELAY;
        end
        opQ.delete();
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          MED_DSO = 1'b1;
          MED_DO  = pend[WIDTH-1:0];
        end
      end
      dsiPrev = (MED_DSI === 1'b1);
    end
  end

  // Downstream ready: held low, held high, or random, updated mid-cycle.
  initial begin : readyDriver
    OUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #3;
      case (outReadyMode)
        0:       OUT_READY = 1'b0;
        1:       OUT_READY = 1'b1;
        default: OUT_READY = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: checks every burst pixel and every new result against the scoreboard.
  initial begin : monitor
    int dsiRun;
    bit ovPrev;
    int e;
    dsiRun = 0;
    ovPrev = 1'b0;
    forever begin
      @(negedge CLK);
      if (nRST !== 1'b1) begin
        dsiRun = 0;
        ovPrev = 1'b0;
        continue;
      end
      if (MED_DSI === 1'b1) begin
        if (burstQ.size() == 0) begin
          checkOutput("dsi_unexpected", 32'(MED_DSI), 0);
        end else begin
          e = burstQ.pop_front();
          checkOutput("med_di", 32'(MED_DI), e);
        end
        dsiRun++;
      end else if (dsiRun != 0) begin
        checkOutput("dsi_burst_len", dsiRun, N_PIXELS);
        checkOutput("med_di_idle", 32'(MED_DI), 0);
        dsiRun = 0;
      end
      if (OUT_VALID === 1'b1 && !ovPrev) begin
        if (expQ.size() == 0) begin
          checkOutput("out_valid_unexpected", 32'(OUT_VALID), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_data", 32'(OUT_DATA), e);
        end
      end
      ovPrev = (OUT_VALID === 1'b1);
    end
  end

  // Main sequence: reset, directed window, hold, alternating valid,
  // timeouts, reset mid-burst with stray strobes, then random traffic.
  initial begin : mainSeq
    int dirPix[9];
    int w;
    logic [WIDTH-1:0] held;
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA = '0;
    CLR_ERR = 1'b0;
    outReadyMode = 1;
    opNever = 1'b0;
    expectNoResult = 1'b0;
    strayCount = 0;
    firstAcceptCyc = 0;
    lastAcceptCyc = 0;
    dirPix = '{90, 10, 80, 20, 70, 30, 60, 40, 50};

    repeat (2) @(negedge CLK);
    checkOutput("rst_in_ready", 32'(IN_READY), 0);
    checkOutput("rst_med_dsi", 32'(MED_DSI), 0);
    checkOutput("rst_med_di", 32'(MED_DI), 0);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 0);
    checkOutput("rst_out_data", 32'(OUT_DATA), 0);
    checkOutput("rst_err", 32'(ERR), 0);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_reset", 32'(IN_READY), 1);

    $display("[TB] directed window 90..50");
    foreach (dirPix[i]) applyStimulus(dirPix[i], 0);
    waitResults();

    $display("[TB] result held while OUT_READY low");
    outReadyMode = 0;
    feedWindow(1);
    w = 0;
    while (OUT_VALID !== 1'b1 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("out_valid_wait", 32'(OUT_VALID), 1);
    held = OUT_DATA;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checkOutput("hold_valid", 32'(OUT_VALID), 1);
      checkOutput("hold_data", 32'(OUT_DATA), 32'(held));
      checkOutput("hold_in_ready", 32'(IN_READY), 0);
      checkOutput("hold_no_burst", 32'(MED_DSI), 0);
    end
    outReadyMode = 1;
    w = 0;
    while (OUT_READY !== 1'b1 && w < 5) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("valid_until_ready", 32'(OUT_VALID), 1);
    @(negedge CLK);
    checkOutput("valid_fall", 32'(OUT_VALID), 0);
    checkOutput("ready_after_accept", 32'(IN_READY), 1);

    $display("[TB] alternating IN_VALID");
    for (int i = 0; i < N_PIXELS; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), 1);
    end
    checkOutput("alt_accept_span", lastAcceptCyc - firstAcceptCyc, 2 * (N_PIXELS - 1));
    waitResults();

    $display("[TB] timeout with mute operator");
    reachWaitEnd();
    checkOutput("err_before_timeout", 32'(ERR), 0);
    @(negedge CLK);
    checkOutput("err_at_timeout", 32'(ERR), 1);
    checkOutput("ready_after_timeout", 32'(IN_READY), 1);
    checkOutput("no_valid_after_timeout", 32'(OUT_VALID), 0);
    repeat (3) @(negedge CLK);
    checkOutput("err_sticky", 32'(ERR), 1);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    checkOutput("err_cleared", 32'(ERR), 0);

    $display("[TB] timeout coinciding with CLR_ERR");
    reachWaitEnd();
    checkOutput("err_before_timeout2", 32'(ERR), 0);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    checkOutput("err_clr_collision", 32'(ERR), 1);
    opNever = 1'b0;

    $display("[TB] reset in 5th SEND cycle");
    feedWindow(0);
    repeat (4) @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(IN_READY), 0);
    checkOutput("midrst_med_dsi", 32'(MED_DSI), 0);
    checkOutput("midrst_med_di", 32'(MED_DI), 0);
    checkOutput("midrst_out_valid", 32'(OUT_VALID), 0);
    checkOutput("midrst_out_data", 32'(OUT_DATA), 0);
    checkOutput("midrst_err", 32'(ERR), 0);
    burstQ.delete();
    expQ.delete();
    winQ.delete();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_midrst", 32'(IN_READY), 1);
    strayCount++;
    repeat (3) @(negedge CLK);
    checkOutput("stray_ignored_valid", 32'(OUT_VALID), 0);
    checkOutput("stray_ignored_ready", 32'(IN_READY), 1);
    for (int i = 0; i < 3; i++) applyStimulus(int'($urandom_range(0, 255)), 0);
    strayCount++;
    for (int i = 3; i < N_PIXELS; i++) applyStimulus(int'($urandom_range(0, 255)), 0);
    waitResults();

    $display("[TB] random windows");
    outReadyMode = 2;
    repeat (6) feedWindow(2);
    waitResults();
    checkOutput("results_drained", expQ.size(), 0);
    checkOutput("bursts_drained", burstQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_driver.md
MEDIAN_DRIVER -- requirements
Module: median_driver

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8: pixel width in bits.
REQ-002 The block SHALL provide parameter N_PIXELS, default 9: pixels per median window.
REQ-003 The block SHALL provide parameter TIMEOUT, default 64: maximum WAIT cycles before error.
REQ-004 The block SHALL provide port CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL provide port nRST  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL provide port IN_VALID  input  1  upstream pixel valid.
REQ-007 The block SHALL provide port IN_DATA  input  WIDTH  upstream pixel.
REQ-008 The block SHALL provide port IN_READY  output  1  block accepts a pixel this cycle.
REQ-009 The block SHALL provide port MED_DSI  output  1  median-operator data strobe in, high during the pixel burst.
REQ-010 The block SHALL provide port MED_DI  output  WIDTH  pixel presented to the median operator.
REQ-011 The block SHALL provide port MED_DSO  input  1  median-operator one-cycle result strobe.
REQ-012 The block SHALL provide port MED_DO  input  WIDTH  median-operator result.
REQ-013 The block SHALL provide port OUT_VALID  output  1  result valid.
REQ-014 The block SHALL provide port OUT_DATA  output  WIDTH  captured median.
REQ-015 The block SHALL provide port OUT_READY  input  1  downstream accepts result.
REQ-016 The block SHALL provide port CLR_ERR  input  1  clears ERR.
REQ-017 The block SHALL provide port ERR  output  1  sticky timeout flag.

Function
REQ-018 The block SHALL implement states LOAD, SEND, WAIT, HOLD; all outputs SHALL be registered.
REQ-019 In LOAD, IN_READY SHALL be 1 and each cycle with IN_VALID=1 SHALL store IN_DATA into buffer slot k, with k incrementing 0..N_PIXELS-1; IN_VALID gaps SHALL stall k.
REQ-020 The cycle after the N_PIXELS-th accept, the state SHALL be SEND and IN_READY SHALL be 0.
REQ-021 In SEND, MED_DSI SHALL be 1 for exactly N_PIXELS consecutive cycles with MED_DI = buffer[0]..buffer[N_PIXELS-1] in order.
REQ-022 After SEND, the state SHALL be WAIT with MED_DSI=0 and MED_DI=0; MED_DSI SHALL stay 0 until the next SEND.
REQ-023 In WAIT, the first cycle with MED_DSO=1 SHALL load OUT_DATA<=MED_DO, set OUT_VALID=1 on the next cycle, and move to HOLD.
REQ-024 In WAIT, a counter SHALL count cycles from 0; if it reaches TIMEOUT with no MED_DSO, ERR SHALL be set, no result SHALL be produced, and the state SHALL return to LOAD with k=0.
REQ-025 In HOLD, OUT_VALID and OUT_DATA SHALL be held stable until a cycle with OUT_READY=1; OUT_VALID SHALL then fall on the next cycle and the state SHALL become LOAD.
REQ-026 OUT_VALID SHALL be high for at least one cycle even when OUT_READY is already 1.
REQ-027 MED_DSO asserted in LOAD, SEND or HOLD SHALL be ignored.
REQ-028 ERR SHALL remain 1 until CLR_ERR=1; if a timeout and CLR_ERR occur in the same cycle, ERR SHALL be 1.
REQ-029 Buffer contents SHALL be overwritten only in LOAD.
REQ-030 Counters SHALL be sized ceil(log2) of their maximum plus 1 bit; no wrap-around SHALL occur within a state.

Reset
REQ-031 When nRST=0, the block SHALL immediately set state=LOAD, k=0, WAIT counter=0, IN_READY=0, MED_DSI=0, MED_DI=0, OUT_VALID=0, OUT_DATA=0, ERR=0.
REQ-032 On the first clock after nRST deasserts, IN_READY SHALL be 1.
REQ-033 Reset asserted mid-SEND, WAIT or HOLD SHALL abort the window with no partial output; buffer contents need not be cleared.

Verification
REQ-034 Bench SHALL feed pixels 90,10,80,20,70,30,60,40,50 with a MEDIAN model returning DSO 12 cycles after DSI falls -> the MED_DI burst matches the input order over 9 DSI cycles, then OUT_DATA=50 with OUT_VALID=1.
REQ-035 Bench SHALL hold OUT_READY=0 for 20 cycles after OUT_VALID -> OUT_VALID and OUT_DATA are stable, IN_READY=0, and no new burst occurs until the accept.
REQ-036 Bench SHALL use a model that never returns DSO -> ERR=1 exactly TIMEOUT=64 cycles into WAIT and no OUT_VALID; then CLR_ERR=1 -> ERR=0 next cycle.
REQ-037 Bench SHALL drive IN_VALID with a 1-on/1-off pattern -> 9 accepts over 18 cycles and a single contiguous 9-cycle MED_DSI burst.
REQ-038 Bench SHALL assert nRST low during the 5th SEND cycle and pulse MED_DSO during LOAD -> all outputs reset immediately, the stray DSO is ignored, and the next full window yields the correct median.
